// File: rtl/mult_approx_pkg.sv
// Shared definitions for the nibble-serial approximate multiplier family:
// FSM state encoding, nibble width and the nibble-count helper.
package mult_approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB = 4;

  // Number of 4-bit nibbles in an operand of width w.
  function automatic int nib_cnt(input int w);
    return w / NIB;
  endfunction

endpackage

// File: rtl/mult_4x4_exact.sv
// Exact combinational 4x4 unsigned multiplier producing an 8-bit product.
// Used once per cycle by the nibble-serial top to form one partial product.
module mult_4x4_exact (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  assign p = 8'(x) * 8'(y);

endmodule

// File: rtl/mult_nxn_approx_seq.sv
// Nibble-serial approximate unsigned multiplier with a valid/ready stream.
// One 4x4 partial product is folded into the accumulator per cycle, A nibble
// outer, B nibble inner. Partial products whose nibble weight (i+j) is below
// approx_lvl are OR-merged; all others are added exactly (mod 2^2W).
// Optional feature macro: MULT_OPCNT_EN adds the 16-bit op_cnt output that
// counts completed output handshakes.
module mult_nxn_approx_seq
  import mult_approx_pkg::*;
#(
  parameter  int W     = 8,
  localparam int LVL_W = $clog2(2*W/4+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [LVL_W-1:0] approx_lvl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   r
`ifdef MULT_OPCNT_EN
  ,
  output logic [15:0]      op_cnt
`endif
);

  localparam int N  = nib_cnt(W);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = 2 * W;

  state_e           state_r;
  state_e           state_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [LVL_W-1:0] lvl_r;
  logic [RW-1:0]    acc_r;
  logic [RW-1:0]    r_r;
  // nib_i_r/nib_j_r together form the step index idx = i*N + j.
  logic [IW-1:0]    nib_i_r;
  logic [IW-1:0]    nib_j_r;

  logic             last_s;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [7:0]       pp_s;
  logic [LVL_W-1:0] weight_s;
  logic [RW-1:0]    sh_s;
  logic [RW-1:0]    acc_nxt_s;

  assign last_s = (nib_i_r == IW'(N-1)) && (nib_j_r == IW'(N-1));

  mult_4x4_exact u_pp (
    .x (a_nib_s),
    .y (b_nib_s),
    .p (pp_s)
  );

  // Select current nibbles, shift the partial product and merge it into acc.
  always_comb begin
    a_nib_s   = 4'(a_r >> (NIB * int'(nib_i_r)));
    b_nib_s   = 4'(b_r >> (NIB * int'(nib_j_r)));
    weight_s  = LVL_W'(nib_i_r) + LVL_W'(nib_j_r);
    sh_s      = RW'(pp_s) << (NIB * int'(weight_s));
    acc_nxt_s = acc_r;
    if (weight_s < lvl_r) begin
      acc_nxt_s = acc_r | sh_s;
    end else begin
      acc_nxt_s = acc_r + sh_s;
    end
  end

  // Next-state logic: IDLE -> CALC on accept, CALC -> DONE after N*N steps,
  // DONE -> IDLE on output handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus registered handshake flags decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, nibble stepping, accumulation and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      lvl_r   <= '0;
      acc_r   <= '0;
      r_r     <= '0;
      nib_i_r <= '0;
      nib_j_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            lvl_r   <= approx_lvl;
            acc_r   <= '0;
            nib_i_r <= '0;
            nib_j_r <= '0;
          end
        end
        CALC: begin
          acc_r <= acc_nxt_s;
          if (last_s) begin
            r_r     <= acc_nxt_s;
            nib_i_r <= '0;
            nib_j_r <= '0;
          end else if (nib_j_r == IW'(N-1)) begin
            nib_j_r <= '0;
            nib_i_r <= nib_i_r + IW'(1);
          end else begin
            nib_j_r <= nib_j_r + IW'(1);
          end
        end
        DONE: begin
          // Result held in r_r; nothing advances until the handshake.
        end
        default: begin
          acc_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign r         = r_r;

`ifdef MULT_OPCNT_EN
  logic [15:0] op_cnt_r;

  // Count completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_r <= 16'd0;
    end else if ((state_r == DONE) && out_ready) begin
      op_cnt_r <= op_cnt_r + 16'd1;
    end else begin
      op_cnt_r <= op_cnt_r;
    end
  end

  assign op_cnt = op_cnt_r;
`endif

endmodule
